// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
// The FAULT state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_INC           = 4;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    FAULT = 3'd5
`endif
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: redirect target, sequential +4, or hold.
// Without FETCH_MISALIGN_TRAP_EN the low two target bits are cleared;
// with it the target is taken as-is and flagged when misaligned.
module pc_next
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc_nxt
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign misaligned = |redirect_pc[1:0];
`else
  assign target     = redirect_pc & ~XLEN'(3);
`endif

  // Redirect wins over the sequential increment; otherwise the PC holds.
  always_comb begin
    pc_nxt = pc;
    if (redirect) begin
      pc_nxt = target;
    end else if (advance) begin
      pc_nxt = pc + XLEN'(PC_INC);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch: owns the PC, issues one memory request at a
// time and presents the returned word in the instruction register.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap).
//
// state | meaning
// BOOT  | first cycle after reset, no request yet
// REQ   | request for pc offered to memory
// WAIT  | request accepted, waiting for the response word
// DROP  | a squashed response is still outstanding; discard it
// HOLD  | instruction register valid, waiting for downstream
// FAULT | misaligned redirect taken; idle until an aligned redirect
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] inflight_pc;
  logic            accept;
  logic            load_ir;
  logic            consume;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misaligned;
  logic            rsp_pending;
`endif

  pc_next #(
    .XLEN(XLEN)
  ) u_pc_next (
    .pc          (pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (load_ir),
    .pc_nxt      (pc_nxt)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misaligned  (misaligned)
`endif
  );

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;

  // Next-state and handshake decode; redirect overrides every other event.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_ir   = 1'b0;
    consume   = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        if (!redirect && imem_req_ready) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_nxt = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          load_ir   = 1'b1;
          state_nxt = HOLD;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_nxt = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = REQ;
        end else if (instr_ready) begin
          consume   = 1'b1;
          state_nxt = REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        if (redirect) begin
          state_nxt = (rsp_pending && !imem_rsp_valid) ? DROP : REQ;
        end
      end
`endif
      default: state_nxt = BOOT;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect && misaligned) begin
      state_nxt = FAULT;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, in-flight address and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (accept) begin
        inflight_pc <= pc;
      end
      if (load_ir) begin
        instr       <= imem_rsp_data;
        instr_pc    <= inflight_pc;
        instr_valid <= 1'b1;
      end else if (redirect || consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Track an outstanding response so FAULT can exit through DROP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pending <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      if (imem_rsp_valid) begin
        rsp_pending <= 1'b0;
      end else if (accept) begin
        rsp_pending <= 1'b1;
      end
      if (redirect) begin
        fetch_fault <= misaligned;
      end
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a memory model with programmable
// latency, a downstream consumer with programmable stalls, and a scoreboard
// of fetched words pushed on request accept and popped on consumption.
module tb_instr_fetch;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;

  always #5 clk = ~clk;

  instr_fetch #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    int          req_stall;
    int          lat;
    int          hold;
    logic [31:0] pc;
    int          cycles;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[5];
  int          total = 0;
  int          bad   = 0;

  logic [31:0] exp_fetch_pc;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          ready_left;
  int          hold_left;
  bit          redir_arm;
  logic [31:0] redir_target;
  int          consumed;
  logic [31:0] last_pc;
  bit          prev_held;
  logic [31:0] prev_instr;
  logic [31:0] prev_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h1234_0013;
  endfunction

  function automatic logic [31:0] redir_pc_model(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs for the current state, update the model,
  // then advance to 1 time unit after the next rising edge.
  task automatic step();
    exp_t e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_busy       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (imem_req_valid && ready_left > 0) begin
      imem_req_ready = 1'b0;
      ready_left--;
    end else begin
      imem_req_ready = 1'b1;
    end
    if (instr_valid && hold_left > 0) begin
      instr_ready = 1'b0;
      hold_left--;
    end else begin
      instr_ready = 1'b1;
    end
    redirect    = redir_arm;
    redirect_pc = redir_target;
    redir_arm   = 1'b0;

    if (imem_req_valid) check("req_addr", imem_addr, exp_fetch_pc);
    if (instr_valid) check("no_req_while_held", 32'(imem_req_valid), 32'd0);
    if (prev_held) begin
      check("hold_instr_stable", instr, prev_instr);
      check("hold_pc_stable", instr_pc, prev_ipc);
    end

    if (redirect) begin
      sb.delete();
      exp_fetch_pc = redir_pc_model(redirect_pc);
    end else begin
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got instr_pc %h with no expected entry", instr_pc);
        end else begin
          e = sb.pop_front();
          check("instr", instr, e.word);
          check("instr_pc", instr_pc, e.pc);
        end
        consumed++;
        last_pc = instr_pc;
      end
      if (imem_req_valid && imem_req_ready) begin
        sb.push_back('{pc: imem_addr, word: mem_word(imem_addr)});
        mem_busy     = 1'b1;
        mem_cnt      = mem_lat;
        mem_addr     = imem_addr;
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    prev_held  = instr_valid && !instr_ready && !redirect;
    prev_instr = instr;
    prev_ipc   = instr_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_consume(output int cycles);
    int n0;
    n0     = consumed;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cycles++;
      if (consumed != n0) break;
    end
    if (consumed == n0) begin
      total++;
      bad++;
      $display("FAIL consume_timeout: got no instruction after %0d cycles, expected one", cycles);
    end
  endtask

  task automatic arm(input logic [31:0] t);
    redir_arm    = 1'b1;
    redir_target = t;
  endtask

  initial begin
    int cyc;

    vecs[0] = '{req_stall: 0, lat: 0, hold: 0, pc: 32'h0,  cycles: 3};
    vecs[1] = '{req_stall: 5, lat: 0, hold: 0, pc: 32'h4,  cycles: 8};
    vecs[2] = '{req_stall: 0, lat: 0, hold: 4, pc: 32'h8,  cycles: 7};
    vecs[3] = '{req_stall: 0, lat: 2, hold: 0, pc: 32'hC,  cycles: 5};
    vecs[4] = '{req_stall: 2, lat: 1, hold: 3, pc: 32'h10, cycles: 9};

    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    exp_fetch_pc   = 32'h0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0; mem_lat = 0;
    ready_left = 0; hold_left = 0; redir_arm = 0; redir_target = '0;
    consumed = 0; last_pc = '0; prev_held = 0; prev_instr = '0; prev_ipc = '0;

    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);

    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);

    // Table of single fetches with request, latency and hold stalls.
    for (int v = 0; v < 5; v++) begin
      ready_left = vecs[v].req_stall;
      mem_lat    = vecs[v].lat;
      hold_left  = vecs[v].hold;
      check("vec_start_req", 32'(imem_req_valid), 32'd1);
      check("vec_start_addr", imem_addr, vecs[v].pc);
      wait_consume(cyc);
      check("vec_cycles", 32'(cyc), 32'(vecs[v].cycles));
      check("vec_instr_pc", last_pc, vecs[v].pc);
    end

    // Redirect while waiting; stale response arrives two cycles later.
    mem_lat = 2;
    step();
    arm(32'h100);
    step();
    check("drop_no_valid", 32'(instr_valid), 32'd0);
    check("drop_no_req", 32'(imem_req_valid), 32'd0);
    step();
    step();
    check("after_drop_req", 32'(imem_req_valid), 32'd1);
    check("after_drop_addr", imem_addr, 32'h100);
    mem_lat = 0;
    wait_consume(cyc);
    check("redir_wait_pc", last_pc, 32'h100);

    // Redirect in the same cycle as the response.
    step();
    arm(32'h200);
    step();
    check("rsp_redir_valid", 32'(instr_valid), 32'd0);
    check("rsp_redir_addr", imem_addr, 32'h200);
    wait_consume(cyc);
    check("rsp_redir_pc", last_pc, 32'h200);

    // Redirect in HOLD while downstream is ready squashes the held word.
    step();
    step();
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_pc", instr_pc, 32'h204);
    arm(32'h300);
    step();
    check("hold_squash_valid", 32'(instr_valid), 32'd0);
    wait_consume(cyc);
    check("hold_redir_pc", last_pc, 32'h300);

    // Redirect in REQ with ready high: request not taken, new address next.
    arm(32'h400);
    step();
    check("req_redir_addr", imem_addr, 32'h400);
    wait_consume(cyc);
    check("req_redir_pc", last_pc, 32'h400);

    // PC wrap at the top of the address space.
    arm(32'hFFFF_FFFC);
    step();
    wait_consume(cyc);
    check("wrap_pc", last_pc, 32'hFFFF_FFFC);
    check("wrap_next_addr", imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect during WAIT, aligned exit before the stale response.
    mem_lat = 3;
    step();
    arm(32'h102);
    step();
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_no_req", 32'(imem_req_valid), 32'd0);
    step();
    check("fault_still", 32'(fetch_fault), 32'd1);
    check("fault_no_req2", 32'(imem_req_valid), 32'd0);
    arm(32'h104);
    step();
    check("fault_clear", 32'(fetch_fault), 32'd0);
    check("fault_drop_no_req", 32'(imem_req_valid), 32'd0);
    step();
    check("fault_exit_addr", imem_addr, 32'h104);
    mem_lat = 0;
    wait_consume(cyc);
    check("fault_exit_pc", last_pc, 32'h104);
`else
    // Without the trap the low target bits are ignored.
    arm(32'h102);
    step();
    check("nofault_flag", 32'(fetch_fault), 32'd0);
    check("nofault_addr", imem_addr, 32'h100);
    wait_consume(cyc);
    check("nofault_pc", last_pc, 32'h100);
`endif

    // Reset in the middle of a transaction.
    mem_lat = 3;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_instr_pc", instr_pc, 32'h0);
    sb.delete();
    mem_busy = 0; mem_lat = 0; exp_fetch_pc = 32'h0; prev_held = 0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_consume(cyc);
    check("post_rst_pc", last_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
